// File: rtl/pe_acc_mac.sv
// pe_acc_mac -- accumulating multiply-accumulate processing element.
//
// Each accepted term converts an integer ifmap value to float32, then forms
// weight * ifmap + psum. The psum is the bias on the first term of a dot
// product, or the internal float32 accumulator on later terms. The result is
// offered on a valid/ready port after the term flagged in_last.
//
// Optional feature: define PE_RELU_EN to clamp the delivered result to +0.0
// whenever its sign bit is set. The accumulator itself is never clamped.
//
// Parameters:
//   IFMAP_W      ifmap width (1..32), extended to 32 bits before conversion
//   IFMAP_SIGNED 1 = sign-extend ifmap, 0 = zero-extend
//   CVT_LAT      int32->float32 converter latency in cycles (>= 1)
//   MAC_LAT      float32 multiply-add latency in cycles (>= 1)
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               term handshake
//   in_first, in_last               dot-product delimiters
//   ifmap, weight, bias             term operands (bias used with in_first only)
//   out_valid/out_ready, ofmap      result handshake and float32 result
//   busy                            high whenever the controller is not idle
module pe_acc_mac #(
   parameter int IFMAP_W      = 32,
   parameter bit IFMAP_SIGNED = 1'b1,
   parameter int CVT_LAT      = 6,
   parameter int MAC_LAT      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_first,
   input  logic               in_last,
   input  logic [IFMAP_W-1:0] ifmap,
   input  logic [31:0]        weight,
   input  logic [31:0]        bias,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        ofmap,
   output logic               busy
);
   localparam int TOT   = CVT_LAT + MAC_LAT;
   localparam int CNT_W = $clog2(TOT + 2);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   // Signed int32 -> float32, round to nearest even.
   function automatic logic [31:0] int_to_f32(input logic [31:0] v);
      logic        s;
      logic [31:0] mag;
      logic [31:0] norm;
      logic [23:0] man;
      logic [8:0]  e;
      int          p;
      s    = v[31];
      mag  = s ? (~v + 32'd1) : v;
      p    = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      norm = mag << (31 - p);
      man  = {1'b0, norm[30:8]};
      e    = 9'(127 + p);
      if (norm[7] && ((|norm[6:0]) || norm[8])) man = man + 24'd1;
      // A rounding carry out of the fraction moves to the next binade.
      if (man[23]) e = e + 9'd1;
      return (mag == 32'd0) ? 32'h0000_0000 : {s, e[7:0], man[22:0]};
   endfunction

   // Fused float32 a*b + c with a single round-to-nearest-even step.
   // Subnormal inputs/results flush to zero; Inf/NaN inputs give a quiet NaN.
   function automatic logic [31:0] f32_fma(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
      logic [23:0] ma, mb, mc;
      logic [47:0] pm;
      logic [73:0] xp, xc, big, sml;
      logic [74:0] r, n;
      logic [24:0] mr;
      logic        sp, sc, sbig, ssml, sr, sticky;
      int          ep, ec, emax, d, q, er;
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF || c[30:23] == 8'hFF) return 32'h7FC0_0000;
      ma = (a[30:23] == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
      mb = (b[30:23] == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
      mc = (c[30:23] == 8'd0) ? 24'd0 : {1'b1, c[22:0]};
      pm = {24'd0, ma} * {24'd0, mb};
      sp = a[31] ^ b[31];
      sc = c[31];
      // Both operands share the scale value = X * 2^(e-127-72); a zero
      // operand gets an exponent far below anything it could disturb.
      ep = (pm == 48'd0) ? -300 : int'(a[30:23]) + int'(b[30:23]) - 127;
      ec = (mc == 24'd0) ? -300 : int'(c[30:23]);
      xp = {pm, 26'd0};
      xc = {1'b0, mc, 49'd0};
      if (ep >= ec) begin
         d = ep - ec; emax = ep; big = xp; sml = xc; sbig = sp; ssml = sc;
      end else begin
         d = ec - ep; emax = ec; big = xc; sml = xp; sbig = sc; ssml = sp;
      end
      if (d > 73) begin
         sticky = |sml;
         sml    = '0;
      end else begin
         sticky = |(sml & ~({74{1'b1}} << d));
         sml    = sml >> d;
      end
      sml[0] = sml[0] | sticky;
      if (sbig == ssml) begin
         r = {1'b0, big} + {1'b0, sml}; sr = sbig;
      end else if (big >= sml) begin
         r = {1'b0, big - sml}; sr = sbig;
      end else begin
         r = {1'b0, sml - big}; sr = ssml;
      end
      // Exact zero: keep the sign only when both addends agree on it.
      if (r == 75'd0) return {sp & sc, 31'd0};
      q = 0;
      for (int i = 0; i < 75; i++) if (r[i]) q = i;
      n  = r << (74 - q);
      er = emax + q - 72;
      mr = {1'b0, n[74:51]};
      if (n[50] && ((|n[49:0]) || n[51])) mr = mr + 25'd1;
      if (mr[24]) begin
         er = er + 1;
         mr = mr >> 1;
      end
      if (er >= 255) return {sr, 8'hFF, 23'd0};
      if (er <= 0)   return {sr, 31'd0};
      return {sr, 8'(er), mr[22:0]};
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      ifmap_q, ifmap_d, weight_q, weight_d, psum_q, psum_d, acc_q, acc_d;
   logic             last_q, last_d;
   logic [31:0]      ifmap_ext, cvt_out, mac_out;

   if (IFMAP_SIGNED) begin : g_sext
      assign ifmap_ext = 32'($signed(ifmap));
   end else begin : g_zext
      assign ifmap_ext = 32'(ifmap);
   end

   // Arithmetic pipelines stand in for the converter and multiply-add cores:
   // free-running, no reset, input sampled every cycle.
   genvar gi;
   for (gi = 0; gi < CVT_LAT; gi++) begin : g_cvt
      logic [31:0] stage_q;
      if (gi == 0) begin : g_head
         always_ff @(posedge clk) stage_q <= int_to_f32(ifmap_q);
      end else begin : g_body
         always_ff @(posedge clk) stage_q <= g_cvt[gi-1].stage_q;
      end
   end
   assign cvt_out = g_cvt[CVT_LAT-1].stage_q;

   for (gi = 0; gi < MAC_LAT; gi++) begin : g_mac
      logic [31:0] stage_q;
      if (gi == 0) begin : g_head
         always_ff @(posedge clk) stage_q <= f32_fma(weight_q, cvt_out, psum_q);
      end else begin : g_body
         always_ff @(posedge clk) stage_q <= g_mac[gi-1].stage_q;
      end
   end
   assign mac_out = g_mac[MAC_LAT-1].stage_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ifmap_d  = ifmap_q;
      weight_d = weight_q;
      psum_d   = psum_q;
      last_d   = last_q;
      acc_d    = acc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               ifmap_d  = ifmap_ext;
               weight_d = weight;
               psum_d   = in_first ? bias : acc_q;
               last_d   = in_last;
               cnt_d    = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            // Operands have been stable for TOT+1 cycles when cnt hits TOT,
            // so the pipeline output no longer depends on earlier contents.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(TOT)) begin
               acc_d   = mac_out;
               cnt_d   = '0;
               state_d = last_q ? S_HOLD : S_IDLE;
            end
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ifmap_q  <= '0;
         weight_q <= '0;
         psum_q   <= '0;
         last_q   <= 1'b0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ifmap_q  <= ifmap_d;
         weight_q <= weight_d;
         psum_q   <= psum_d;
         last_q   <= last_d;
         acc_q    <= acc_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_HOLD);
   assign busy      = (state_q != S_IDLE);
`ifdef PE_RELU_EN
   assign ofmap = acc_q[31] ? 32'h0000_0000 : acc_q;
`else
   assign ofmap = acc_q;
`endif

endmodule

// File: doc/pe_acc_mac.md
# pe_acc_mac

Accumulating multiply-accumulate processing element for the MNIST inference datapath. Each accepted term converts an integer ifmap value (width set by parameter) to float32 with INT32_to_FLOAT32, then forms weight × ifmap + psum with FP_MAC. The psum is either the supplied bias (first term) or an internal float32 accumulator (later terms). It runs a complete dot product over a first/last-delimited stream and delivers one float32 result over a valid/ready output, replacing the single-shot PE used in the conv/FC layers.

## Interface

- IFMAP_W, 32: ifmap width, 1..32; extended to 32 bits before conversion.
- IFMAP_SIGNED, 1: 1 = sign-extend ifmap, 0 = zero-extend.
- CVT_LAT, 6: INT32_to_FLOAT32 latency in cycles; must match IP configuration.
- MAC_LAT, 16: FP_MAC latency in cycles; must match IP configuration.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  term available.
- in_ready  out  1  term accepted when in_valid && in_ready.
- in_first  in  1  term is the first of a dot product; psum = bias.
- in_last  in  1  term is the last of a dot product; result is emitted.
- ifmap  in  IFMAP_W  integer activation.
- weight  in  32  float32 weight.
- bias  in  32  float32 bias, sampled only with in_first.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid && out_ready.
- ofmap  out  32  float32 result.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation

- FSM states: IDLE, BUSY, HOLD. in_ready = (state == IDLE).
- IDLE, on accept:
  - Register ext(ifmap), weight, psum_sel = in_first ? bias : acc, and last_q = in_last.
  - Go to BUSY with cnt = 0.
- BUSY: operand registers are held constant. The converter input comes from the ifmap register; the FP_MAC operands are weight_q, the converter output, and psum_q. Both IPs have tvalid tied 1.
  - cnt increments each cycle.
  - When cnt == CVT_LAT+MAC_LAT (TOT), capture the FP_MAC result into acc. Next state is HOLD if last_q, else IDLE.
- HOLD: out_valid = 1 and ofmap is driven from acc. On out_ready, go to IDLE. acc is not cleared.
- A term without in_first continues from acc. After reset, acc = 0x00000000 (+0.0).
- in_first && in_last in one term gives ofmap = weight × ifmap + bias.
- The IPs have no reset. Stale pipeline contents are never captured, because operands are held for TOT+1 cycles, which is at least each IP's latency.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, ofmap 0, acc 0, cnt 0, all operand registers 0.
- Reset mid-operation: any term in flight and any held result are dropped. Transfers are ignored while rst_n is low.

## Timing

- Accept on the edge ending cycle k. BUSY runs over cycles k+1 … k+1+TOT, and acc is updated on the edge ending cycle k+1+TOT.
- Non-last term: in_ready is high again in cycle k+2+TOT. Throughput is one term per TOT+2 cycles.
- Last term: out_valid is high from cycle k+2+TOT until the handshake. in_ready rises the cycle after the handshake.
- While out_valid is high, ofmap is stable and in_ready is 0.
- in_valid while in_ready is 0 has no effect. Input data need only be valid in the accept cycle.

## Configuration

- PE_RELU_EN defined: ofmap = acc[31] ? 32'h00000000 : acc. This covers −0.0 and negative NaN. acc itself is unmodified.
- PE_RELU_EN undefined: ofmap = acc.

## Test plan

- Single term, defaults: bias 0x3F800000 (1.0), weight 0x40000000 (2.0), ifmap 3, first & last → out_valid exactly TOT+2 cycles after the accept cycle, ofmap 0x40E00000 (7.0).
- Three terms: bias 0.5, (weight, ifmap) = (1.0, 4), (2.0, 5), (−1.0, −2) → single output 0x41840000 (16.5). in_ready is low for TOT+1 cycles after each accept; no output after terms 1 and 2.
- Backpressure: hold out_ready = 0 for 10 cycles with out_valid high → ofmap stable, in_ready 0, busy 1. Asserting out_ready gives one handshake, then in_ready is 1 in the next cycle.
- IFMAP_W=8, IFMAP_SIGNED=1: ifmap 8'hFF, weight 1.0, bias 0.0 → 0xBF800000. With PE_RELU_EN → 0x00000000. With IFMAP_SIGNED=0 → 0x437F0000 (255.0).
- Reset mid-BUSY: pulse rst_n low at cnt = 5 → out_valid 0, in_ready 1, busy 0 immediately. The next single-term op (2.0 × 3 + 1.0) yields 0x40E00000 with no stale result.
- Protocol: hold in_valid with changing data while in_ready = 0 → no extra terms accumulated; the final result equals the golden sum of accepted terms only.
